// File: rtl/alu_execute_unit.sv
// Execute stage feeding the register-file write port: single-cycle ALU ops
// plus a fixed-latency shift-add multiply, with registered result and flags.
module alu_execute_unit #(
    parameter int unsigned DATA_WIDTH     = 24,
    parameter int unsigned REG_ADDR_WIDTH = 5,
    parameter int unsigned MUL_CYCLES     = 24
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [3:0]                opcode,
    input  logic [DATA_WIDTH-1:0]     operand_a,
    input  logic [DATA_WIDTH-1:0]     operand_b,
    input  logic [REG_ADDR_WIDTH-1:0] dest_reg_in,
    output logic                      busy,
    output logic                      done,
    output logic [DATA_WIDTH-1:0]     result,
    output logic [REG_ADDR_WIDTH-1:0] result_reg,
    output logic                      write_enable,
    output logic                      zero,
    output logic                      negative,
    output logic                      carry,
    output logic                      overflow
);

    localparam int unsigned CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_CYCLES - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_MUL  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_NOT  = 4'd5;
    localparam logic [3:0] OP_SLL  = 4'd6;
    localparam logic [3:0] OP_SRL  = 4'd7;
    localparam logic [3:0] OP_SRA  = 4'd8;
    localparam logic [3:0] OP_MUL  = 4'd9;
    localparam logic [3:0] OP_PASS = 4'd10;
    localparam logic [3:0] OP_SLT  = 4'd11;

    logic [1:0]                r_state;
    logic [1:0]                w_next_state;
    logic [3:0]                r_op;
    logic [DATA_WIDTH-1:0]     r_a;
    logic [DATA_WIDTH-1:0]     r_b;
    logic [DATA_WIDTH-1:0]     r_acc;
    logic [REG_ADDR_WIDTH-1:0] r_dest;
    logic [CNT_W-1:0]          r_cnt;
    logic                      r_busy;
    logic                      r_done;
    logic                      r_we;
    logic [DATA_WIDTH-1:0]     r_result;
    logic [REG_ADDR_WIDTH-1:0] r_result_reg;
    logic                      r_zero;
    logic                      r_negative;
    logic                      r_carry;
    logic                      r_overflow;

    logic                      w_legal;
    logic [DATA_WIDTH:0]       w_sum;
    logic [DATA_WIDTH:0]       w_diff;
    logic [4:0]                w_shamt;
    logic                      w_sh_big;
    logic [DATA_WIDTH-1:0]     w_alu_res;
    logic                      w_alu_c;
    logic                      w_alu_v;
    logic [DATA_WIDTH-1:0]     w_mul_acc;

    assign w_legal   = (r_op <= OP_SLT);
    assign w_sum     = {1'b0, r_a} + {1'b0, r_b};
    assign w_diff    = {1'b0, r_a} - {1'b0, r_b};
    assign w_shamt   = r_b[4:0];
    assign w_sh_big  = (32'(w_shamt) >= DATA_WIDTH);
    assign w_mul_acc = r_acc + (r_b[0] ? r_a : '0);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next_state = (opcode == OP_MUL) ? S_MUL : S_EXEC;
            S_EXEC:  w_next_state = S_DONE;
            S_MUL:   if (r_cnt == CNT_LAST) w_next_state = S_DONE;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Single-cycle ALU; carry means borrow for SUB
    always_comb begin
        w_alu_res = '0;
        w_alu_c   = 1'b0;
        w_alu_v   = 1'b0;
        case (r_op)
            OP_ADD: begin
                w_alu_res = w_sum[DATA_WIDTH-1:0];
                w_alu_c   = w_sum[DATA_WIDTH];
                w_alu_v   = (r_a[DATA_WIDTH-1] == r_b[DATA_WIDTH-1]) &&
                            (w_sum[DATA_WIDTH-1] != r_a[DATA_WIDTH-1]);
            end
            OP_SUB: begin
                w_alu_res = w_diff[DATA_WIDTH-1:0];
                w_alu_c   = w_diff[DATA_WIDTH];
                w_alu_v   = (r_a[DATA_WIDTH-1] != r_b[DATA_WIDTH-1]) &&
                            (w_diff[DATA_WIDTH-1] != r_a[DATA_WIDTH-1]);
            end
            OP_AND:  w_alu_res = r_a & r_b;
            OP_OR:   w_alu_res = r_a | r_b;
            OP_XOR:  w_alu_res = r_a ^ r_b;
            OP_NOT:  w_alu_res = ~r_a;
            OP_SLL:  w_alu_res = w_sh_big ? '0 : (r_a << w_shamt);
            OP_SRL:  w_alu_res = w_sh_big ? '0 : (r_a >> w_shamt);
            OP_SRA:  w_alu_res = w_sh_big ? {DATA_WIDTH{r_a[DATA_WIDTH-1]}}
                                          : DATA_WIDTH'($signed(r_a) >>> w_shamt);
            OP_PASS: w_alu_res = r_b;
            OP_SLT:  w_alu_res = {{(DATA_WIDTH-1){1'b0}}, ($signed(r_a) < $signed(r_b))};
            default: w_alu_res = '0;
        endcase
    end

    // Operand latch, multiply iteration, result/flag and strobe registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op         <= '0;
            r_a          <= '0;
            r_b          <= '0;
            r_acc        <= '0;
            r_dest       <= '0;
            r_cnt        <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_we         <= 1'b0;
            r_result     <= '0;
            r_result_reg <= '0;
            r_zero       <= 1'b0;
            r_negative   <= 1'b0;
            r_carry      <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_busy <= (w_next_state != S_IDLE);
            r_done <= (w_next_state == S_DONE);
            r_we   <= (w_next_state == S_DONE) && w_legal;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_op   <= opcode;
                        r_a    <= operand_a;
                        r_b    <= operand_b;
                        r_dest <= dest_reg_in;
                        r_acc  <= '0;
                        r_cnt  <= '0;
                    end
                end
                S_EXEC: begin
                    r_result_reg <= r_dest;
                    if (w_legal) begin
                        r_result   <= w_alu_res;
                        r_zero     <= (w_alu_res == '0);
                        r_negative <= w_alu_res[DATA_WIDTH-1];
                        r_carry    <= w_alu_c;
                        r_overflow <= w_alu_v;
                    end else begin
                        r_result <= '0;
                    end
                end
                S_MUL: begin
                    r_acc <= w_mul_acc;
                    r_a   <= r_a << 1;
                    r_b   <= r_b >> 1;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_LAST) begin
                        r_cnt        <= '0;
                        r_result     <= w_mul_acc;
                        r_result_reg <= r_dest;
                        r_zero       <= (w_mul_acc == '0);
                        r_negative   <= w_mul_acc[DATA_WIDTH-1];
                        r_carry      <= 1'b0;
                        r_overflow   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy         = r_busy;
    assign done         = r_done;
    assign write_enable = r_we;
    assign result       = r_result;
    assign result_reg   = r_result_reg;
    assign zero         = r_zero;
    assign negative     = r_negative;
    assign carry        = r_carry;
    assign overflow     = r_overflow;

endmodule

// File: tb/tb_alu_execute_unit.sv
// Directed bench for alu_execute_unit: latency, results, flags, illegal ops
// and asynchronous reset during a multiply.
module tb_alu_execute_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [3:0]  opcode;
    logic [23:0] operand_a;
    logic [23:0] operand_b;
    logic [4:0]  dest_reg_in;
    logic        busy;
    logic        done;
    logic [23:0] result;
    logic [4:0]  result_reg;
    logic        write_enable;
    logic        zero;
    logic        negative;
    logic        carry;
    logic        overflow;
    logic [3:0]  flags;

    int n_cmp  = 0;
    int n_fail = 0;

    assign flags = {zero, negative, carry, overflow};

    always #5 clk = ~clk;

    alu_execute_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .opcode       (opcode),
        .operand_a    (operand_a),
        .operand_b    (operand_b),
        .dest_reg_in  (dest_reg_in),
        .busy         (busy),
        .done         (done),
        .result       (result),
        .result_reg   (result_reg),
        .write_enable (write_enable),
        .zero         (zero),
        .negative     (negative),
        .carry        (carry),
        .overflow     (overflow)
    );

    // Raise start just after edge E; returns cycles until done is seen (40 = timeout).
    task automatic run_op(input logic [3:0] op, input logic [23:0] a, input logic [23:0] b,
                          input logic [4:0] d, output int lat, output logic we);
        @(posedge clk); #1;
        start = 1'b1; opcode = op; operand_a = a; operand_b = b; dest_reg_in = d;
        lat = 0;
        we  = 1'b0;
        while (lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (lat == 1) begin
                start       = 1'b0;
                operand_a   = 24'($urandom);
                operand_b   = 24'($urandom);
                opcode      = 4'($urandom);
                dest_reg_in = 5'($urandom);
            end
            if (done === 1'b1) begin
                we = write_enable;
                break;
            end
        end
    endtask

    task automatic test_reset();
        n_cmp++;
        if ({busy, done, write_enable} !== 3'b000) begin
            n_fail++; $display("FAIL reset_ctrl: got %b want 000", {busy, done, write_enable});
        end
        n_cmp++;
        if (result !== 24'h0 || result_reg !== 5'd0) begin
            n_fail++; $display("FAIL reset_result: got %h/%0d want 0/0", result, result_reg);
        end
        n_cmp++;
        if (flags !== 4'b0000) begin
            n_fail++; $display("FAIL reset_flags: got %b want 0000", flags);
        end
    endtask

    task automatic test_add();
        int lat; logic we;
        run_op(4'd0, 24'h7FFFFF, 24'h000001, 5'd3, lat, we);
        n_cmp++;
        if (lat !== 2) begin n_fail++; $display("FAIL add_latency: got %0d want 2", lat); end
        n_cmp++;
        if (we !== 1'b1) begin n_fail++; $display("FAIL add_we: got %b want 1", we); end
        n_cmp++;
        if (result !== 24'h800000 || result_reg !== 5'd3) begin
            n_fail++; $display("FAIL add_result: got %h/%0d want 800000/3", result, result_reg);
        end
        n_cmp++;
        if (flags !== 4'b0101) begin n_fail++; $display("FAIL add_flags: got %b want 0101", flags); end
        @(posedge clk); #1;
        n_cmp++;
        if ({busy, done, write_enable} !== 3'b000) begin
            n_fail++; $display("FAIL add_pulse_end: got %b want 000", {busy, done, write_enable});
        end
        n_cmp++;
        if (result !== 24'h800000 || result_reg !== 5'd3) begin
            n_fail++; $display("FAIL add_hold: got %h/%0d want 800000/3", result, result_reg);
        end
    endtask

    task automatic test_sub();
        int lat; logic we;
        run_op(4'd1, 24'd5, 24'd7, 5'd4, lat, we);
        n_cmp++;
        if (result !== 24'hFFFFFE || flags !== 4'b0110) begin
            n_fail++; $display("FAIL sub_borrow: got %h/%b want fffffe/0110", result, flags);
        end
        run_op(4'd1, 24'h123456, 24'h123456, 5'd5, lat, we);
        n_cmp++;
        if (result !== 24'h0 || flags !== 4'b1000 || lat !== 2) begin
            n_fail++; $display("FAIL sub_zero: got %h/%b lat %0d want 0/1000 lat 2", result, flags, lat);
        end
    endtask

    task automatic test_mul();
        int lat; int busy_bad; logic we;
        @(posedge clk); #1;
        start = 1'b1; opcode = 4'd9; operand_a = 24'h001000; operand_b = 24'h000800; dest_reg_in = 5'd6;
        lat = 0; busy_bad = 0;
        while (lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (lat == 1) begin start = 1'b0; operand_a = 24'h0; operand_b = 24'h0; end
            if (lat == 10) begin start = 1'b1; opcode = 4'd0; operand_a = 24'd1; end
            if (lat == 11) start = 1'b0;
            if (done === 1'b1) break;
            if (busy !== 1'b1) busy_bad++;
        end
        we = write_enable;
        n_cmp++;
        if (lat !== 25) begin n_fail++; $display("FAIL mul_latency: got %0d want 25", lat); end
        n_cmp++;
        if (busy_bad !== 0) begin n_fail++; $display("FAIL mul_busy: got %0d low cycles want 0", busy_bad); end
        n_cmp++;
        if (result !== 24'h800000 || result_reg !== 5'd6 || we !== 1'b1) begin
            n_fail++; $display("FAIL mul_result: got %h/%0d we %b want 800000/6 we 1", result, result_reg, we);
        end
        n_cmp++;
        if (flags !== 4'b0100) begin n_fail++; $display("FAIL mul_flags: got %b want 0100", flags); end
        busy_bad = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (done !== 1'b0 || busy !== 1'b0) busy_bad++;
        end
        n_cmp++;
        if (busy_bad !== 0) begin n_fail++; $display("FAIL mul_start_ignored: got %0d active cycles want 0", busy_bad); end
        run_op(4'd9, 24'hFFFFFF, 24'hFFFFFF, 5'd7, lat, we);
        n_cmp++;
        if (result !== 24'h000001 || flags !== 4'b0000 || lat !== 25) begin
            n_fail++; $display("FAIL mul_wrap: got %h/%b lat %0d want 000001/0000 lat 25", result, flags, lat);
        end
    endtask

    task automatic test_shift();
        int lat; logic we;
        run_op(4'd8, 24'h800000, 24'd30, 5'd8, lat, we);
        n_cmp++;
        if (result !== 24'hFFFFFF || flags !== 4'b0100) begin
            n_fail++; $display("FAIL sra_big: got %h/%b want ffffff/0100", result, flags);
        end
        run_op(4'd6, 24'h000001, 24'd24, 5'd9, lat, we);
        n_cmp++;
        if (result !== 24'h0 || flags !== 4'b1000) begin
            n_fail++; $display("FAIL sll_24: got %h/%b want 0/1000", result, flags);
        end
        run_op(4'd7, 24'h800000, 24'd23, 5'd10, lat, we);
        n_cmp++;
        if (result !== 24'h000001 || flags !== 4'b0000) begin
            n_fail++; $display("FAIL srl_23: got %h/%b want 000001/0000", result, flags);
        end
        run_op(4'd11, 24'hFFFFFF, 24'h000001, 5'd11, lat, we);
        n_cmp++;
        if (result !== 24'h000001 || we !== 1'b1) begin
            n_fail++; $display("FAIL slt_signed: got %h we %b want 000001 we 1", result, we);
        end
    endtask

    task automatic test_illegal();
        int lat; logic we;
        run_op(4'd1, 24'd5, 24'd7, 5'd12, lat, we);
        run_op(4'd15, 24'h000123, 24'h000456, 5'd13, lat, we);
        n_cmp++;
        if (lat !== 2 || we !== 1'b0) begin
            n_fail++; $display("FAIL illegal_strobe: got lat %0d we %b want lat 2 we 0", lat, we);
        end
        n_cmp++;
        if (result !== 24'h0 || flags !== 4'b0110) begin
            n_fail++; $display("FAIL illegal_result: got %h/%b want 0/0110", result, flags);
        end
    endtask

    task automatic test_reset_mid();
        int lat; int bad; logic we;
        run_op(4'd1, 24'd5, 24'd7, 5'd14, lat, we);
        @(posedge clk); #1;
        start = 1'b1; opcode = 4'd9; operand_a = 24'd3; operand_b = 24'd3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({busy, done, write_enable} !== 3'b000) begin
            n_fail++; $display("FAIL rstmid_ctrl: got %b want 000", {busy, done, write_enable});
        end
        n_cmp++;
        if (result !== 24'h0 || flags !== 4'b0000) begin
            n_fail++; $display("FAIL rstmid_data: got %h/%b want 0/0000", result, flags);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (done !== 1'b0 || write_enable !== 1'b0 || busy !== 1'b0) bad++;
        end
        n_cmp++;
        if (bad !== 0) begin n_fail++; $display("FAIL rstmid_no_pulse: got %0d active cycles want 0", bad); end
        run_op(4'd0, 24'd2, 24'd3, 5'd15, lat, we);
        n_cmp++;
        if (result !== 24'd5 || lat !== 2 || we !== 1'b1 || result_reg !== 5'd15) begin
            n_fail++; $display("FAIL rstmid_add: got %h lat %0d we %b reg %0d want 5 lat 2 we 1 reg 15",
                               result, lat, we, result_reg);
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; opcode = 4'd0;
        operand_a = 24'h0; operand_b = 24'h0; dest_reg_in = 5'd0;
        #12;
        test_reset();
        rst_n = 1'b1;
        test_add();
        test_sub();
        test_mul();
        test_shift();
        test_illegal();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
